bias_dac_ctrl: RTL and testbench
================================

# bias_dac_ctrl

Digital front-end for the dual-channel 4-bit R-2R bias DAC in the SVF path. It maps the filter cutoff and resonance registers onto the fc and Q DAC codes. It slew-limits every code change to one LSB per step, so the OTA bias never jumps. It parks the filter at a safe bias when filtering is disabled. Its `d_fc`/`d_q` outputs drive the DAC digital inputs directly.

## Interface
Parameters:
- `STEP_DIV`, 4: number of `tick` strobes per one-LSB slew step; legal range 1..255.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `tick`, input, 1: sample-rate strobe, one `clk` wide.
- `fc_reg`, input, 11: SID filter cutoff register.
- `res`, input, 4: SID resonance register.
- `filt_en`, input, 1: filter enabled; 0 selects the park codes.
- `d_fc`, output, 4: fc DAC code (registered).
- `d_q`, output, 4: Q DAC code (registered).
- `settled`, output, 1: high when both codes equal their targets and no ramp is in progress.

## Operation
- Target mapping, registered every `clk` into `tgt_fc`/`tgt_q`:
  - `filt_en`=1: `tgt_fc` = `fc_reg[10:7]`, `tgt_q` = ~`res`. Higher resonance gives lower damping bias.
  - `filt_en`=0: `tgt_fc` = 4'h0, `tgt_q` = 4'hF (park codes).
- FSM states:
  - SETTLED → RAMP when (`tgt_fc` != `d_fc`) or (`tgt_q` != `d_q`).
  - RAMP → SETTLED when both post-step codes equal the current targets.
- Prescaler `pcnt`, 8 bits:
  - Held at 0 in SETTLED.
  - In RAMP, increments on each `tick` and wraps to 0 at STEP_DIV-1.
  - `step` = RAMP & `tick` & (`pcnt` == STEP_DIV-1).
- On `step`, each channel independently moves one LSB toward its own target:
  - `code` < `tgt`: `code` + 1.
  - `code` > `tgt`: `code` − 1.
  - Equal: hold.
  - Codes saturate at 0 and 15 and never wrap.
- Retarget mid-ramp: the direction is recomputed at every step from the current target. A channel never overshoots or oscillates. `pcnt` is not cleared on retarget.
- Target changing on the same cycle as `step`: the step uses the registered target from the previous cycle.
- `settled` = (state == SETTLED).

## Timing
- Reset values: `d_fc` = 0, `d_q` = 4'hF, `tgt_fc` = 0, `tgt_q` = 4'hF, `pcnt` = 0, state = SETTLED, `settled` = 1.
- Input change at edge N:
  - `tgt_*` updates at N+1.
  - State enters RAMP at N+2 and `settled` falls at N+2.
- First code move occurs on the STEP_DIV-th `tick` sampled in RAMP.
- Full-scale swing: 15 steps = 15·STEP_DIV ticks.
- `settled` rises on the `clk` after the final step.
- `tick` while in SETTLED is ignored.
- `rst` asserted mid-ramp immediately forces all reset values; there is no partial step.

## Configuration
- `BIAS_DAC_SLEW_EN` defined: slew behaviour as above.
- `BIAS_DAC_SLEW_EN` undefined:
  - Prescaler and FSM are removed.
  - `d_fc`/`d_q` load `tgt_fc`/`tgt_q` on the next `clk`, two cycles after the input changes.
  - `settled` = (`d_fc` == `tgt_fc`) & (`d_q` == `tgt_q`), registered.
  - STEP_DIV is ignored.

## Structure
- Shared package `bias_dac_pkg`:
  - `DAC_W` = 4.
  - `FC_PARK` = 4'h0, `Q_PARK` = 4'hF.
  - FSM state enum {SETTLED, RAMP}.
- One sub-module `bias_slew_ch` holds one channel's code register and up/down/hold step logic with saturation. It is instantiated twice (fc, Q). FSM and prescaler stay in the top level.

## Test plan
- Reset, STEP_DIV=2, `filt_en`=1, `fc_reg`=11'h7FF, `res`=4'hF, `tick` every cycle:
  - `d_fc` 0→15 and `d_q` 15→0, one LSB every 2 ticks.
  - `settled` high after 30 ticks plus pipeline latency.
- Settled at `d_fc`=12; drop `filt_en` → `d_fc` ramps down to 0 and `d_q` ramps to 15; both monotonic.
- Mid-ramp up at `d_fc`=6, change `fc_reg` to 11'h180 (target 3) → next step gives 5, then 4, then 3; `settled` rises; no code above 6.
- Tick gaps: `tick` every 7 cycles, STEP_DIV=3 → consecutive code changes exactly 21 cycles apart.
- `rst` pulse mid-ramp → outputs return to 0/F the same cycle; the ramp restarts from the reset codes after release.
- `BIAS_DAC_SLEW_EN` undefined, `fc_reg`=11'h400 (target 8) → `d_fc`=8 two cycles after the input change; `settled` high the cycle after.

Source files
------------

// File: rtl/bias_dac_pkg.sv
// Shared definitions for the bias DAC front-end: code width, park codes and FSM states.
package bias_dac_pkg;

    localparam int DAC_W = 4;

    localparam logic [DAC_W-1:0] FC_PARK = 4'h0;
    localparam logic [DAC_W-1:0] Q_PARK  = 4'hF;

    typedef enum logic {
        SETTLED,
        RAMP
    } state_t;

endpackage

// File: rtl/bias_slew_ch.sv
// One DAC channel: code register with one-LSB saturating step toward its target.
// With BIAS_DAC_SLEW_EN undefined a step loads the target directly.
module bias_slew_ch
    import bias_dac_pkg::*;
#(
    parameter logic [DAC_W-1:0] RST_CODE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [DAC_W-1:0] tgt,
    output logic [DAC_W-1:0] code,
    output logic             hit
);

    logic [DAC_W-1:0] nxt;

    // hit reports the post-step code against the target so the FSM can leave RAMP on the final step
    always_comb begin
        nxt = code;
`ifdef BIAS_DAC_SLEW_EN
        if (step) begin
            if (code < tgt && code != '1) begin
                nxt = code + DAC_W'(1);
            end else if (code > tgt && code != '0) begin
                nxt = code - DAC_W'(1);
            end
        end
        hit = (nxt == tgt);
`else
        if (step) begin
            nxt = tgt;
        end
        hit = (code == tgt);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code <= RST_CODE;
        end else begin
            code <= nxt;
        end
    end

endmodule

// File: rtl/bias_dac_ctrl.sv
// Bias DAC front-end: maps cutoff/resonance onto fc/Q DAC codes with optional slew limiting.
// Slew limiting (FSM + prescaler) is built only when BIAS_DAC_SLEW_EN is defined.
module bias_dac_ctrl
    import bias_dac_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [10:0]      fc_reg,
    input  logic [3:0]       res,
    input  logic             filt_en,
    output logic [DAC_W-1:0] d_fc,
    output logic [DAC_W-1:0] d_q,
    output logic             settled
);

    logic [DAC_W-1:0] tgt_fc;
    logic [DAC_W-1:0] tgt_q;
    logic             step;
    logic             fc_hit;
    logic             q_hit;
    logic [6:0]       unused_fc_lsb;

    assign unused_fc_lsb = fc_reg[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_fc <= FC_PARK;
            tgt_q  <= Q_PARK;
        end else if (filt_en) begin
            tgt_fc <= fc_reg[10:7];
            tgt_q  <= ~res;
        end else begin
            tgt_fc <= FC_PARK;
            tgt_q  <= Q_PARK;
        end
    end

    bias_slew_ch #(.RST_CODE(FC_PARK)) u_fc (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .tgt  (tgt_fc),
        .code (d_fc),
        .hit  (fc_hit)
    );

    bias_slew_ch #(.RST_CODE(Q_PARK)) u_q (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .tgt  (tgt_q),
        .code (d_q),
        .hit  (q_hit)
    );

`ifdef BIAS_DAC_SLEW_EN
    localparam logic [7:0] DIV_M1 = 8'(STEP_DIV - 1);

    state_t     state;
    logic [7:0] pcnt;

    assign step = (state == RAMP) && tick && (pcnt == DIV_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SETTLED;
            pcnt    <= '0;
            settled <= 1'b1;
        end else begin
            case (state)
                SETTLED: begin
                    pcnt <= '0;
                    if (tgt_fc != d_fc || tgt_q != d_q) begin
                        state   <= RAMP;
                        settled <= 1'b0;
                    end
                end
                RAMP: begin
                    // prescaler keeps its phase across retargets; cleared only on leaving RAMP
                    if (fc_hit && q_hit) begin
                        state   <= SETTLED;
                        settled <= 1'b1;
                        pcnt    <= '0;
                    end else if (tick) begin
                        pcnt <= (pcnt == DIV_M1) ? '0 : pcnt + 8'd1;
                    end
                end
                default: begin
                    state   <= SETTLED;
                    settled <= 1'b1;
                    pcnt    <= '0;
                end
            endcase
        end
    end
`else
    // tick and STEP_DIV have no effect without slew limiting
    logic [8:0] unused_cfg;
    assign unused_cfg = {tick, 8'(STEP_DIV)};

    assign step = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settled <= 1'b1;
        end else begin
            settled <= fc_hit & q_hit;
        end
    end
`endif

endmodule

// File: tb/tb_bias_dac_ctrl.sv
// Self-checking bench for bias_dac_ctrl: two instances (STEP_DIV 2 and 3) against a behavioural model.
// Honours BIAS_DAC_SLEW_EN the same way as the design.
module tb_bias_dac_ctrl;

    localparam int DIVS [2] = '{2, 3};

    logic        clk;
    logic        rst;
    logic        tick;
    logic [10:0] fc_reg;
    logic [3:0]  res;
    logic        filt_en;
    logic [3:0]  dfc  [2];
    logic [3:0]  dq   [2];
    logic        dset [2];

    int n_cmp;
    int n_bad;

    int m_fc [2];
    int m_q  [2];
    int m_tfc[2];
    int m_tq [2];
    int m_ph [2];
    bit m_ramp[2];
    bit m_set[2];

    bias_dac_ctrl #(.STEP_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .fc_reg(fc_reg), .res(res),
        .filt_en(filt_en), .d_fc(dfc[0]), .d_q(dq[0]), .settled(dset[0])
    );

    bias_dac_ctrl #(.STEP_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .fc_reg(fc_reg), .res(res),
        .filt_en(filt_en), .d_fc(dfc[1]), .d_q(dq[1]), .settled(dset[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int toward(input int c, input int t);
        return (c < t) ? c + 1 : ((c > t) ? c - 1 : c);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_fc[k] = 0;  m_q[k] = 15;
            m_tfc[k] = 0; m_tq[k] = 15;
            m_ph[k] = 0;  m_ramp[k] = 1'b0; m_set[k] = 1'b1;
        end
    endtask

    // Advance the model by one clock using the inputs as sampled at that edge.
    task automatic model_edge();
        int nt_fc;
        int nt_q;
        nt_fc = filt_en ? int'(fc_reg >> 7) : 0;
        nt_q  = filt_en ? 15 - int'(res) : 15;
        for (int k = 0; k < 2; k++) begin
`ifdef BIAS_DAC_SLEW_EN
            if (!m_ramp[k]) begin
                m_ramp[k] = (m_fc[k] != m_tfc[k]) || (m_q[k] != m_tq[k]);
            end else begin
                bit mv;
                mv = 1'b0;
                if (tick) begin
                    m_ph[k]++;
                    if (m_ph[k] == DIVS[k]) begin
                        m_ph[k] = 0;
                        mv = 1'b1;
                    end
                end
                if (mv) begin
                    m_fc[k] = toward(m_fc[k], m_tfc[k]);
                    m_q[k]  = toward(m_q[k], m_tq[k]);
                end
                if (m_fc[k] == m_tfc[k] && m_q[k] == m_tq[k]) begin
                    m_ramp[k] = 1'b0;
                    m_ph[k] = 0;
                end
            end
            m_set[k] = !m_ramp[k];
`else
            m_set[k] = (m_fc[k] == m_tfc[k]) && (m_q[k] == m_tq[k]);
            m_fc[k]  = m_tfc[k];
            m_q[k]   = m_tq[k];
`endif
            m_tfc[k] = nt_fc;
            m_tq[k]  = nt_q;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d_fc[%0d]", k), dfc[k], m_fc[k]);
            check($sformatf("d_q[%0d]", k), dq[k], m_q[k]);
            check($sformatf("settled[%0d]", k), dset[k], m_set[k]);
        end
    endtask

    task automatic check_reset_now(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_fc[%0d]", tag, k), dfc[k], 0);
            check($sformatf("%s_q[%0d]", tag, k), dq[k], 15);
            check($sformatf("%s_set[%0d]", tag, k), dset[k], 1);
        end
    endtask

    task automatic settle(input string tag, input int budget);
        int n;
        n = 0;
        tick = 1'b1;
        repeat (3) cycle();
        while (!(dset[0] && dset[1]) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done"}, int'(dset[0] && dset[1]), 1);
    endtask

    initial begin
        int first[2];
        bit low[2];
        int exp_first;
        int peak;
        int prev_fc[2];
        int prev_q[2];
        int last_chg;
        int c;
        int vals[$];

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; tick = 1'b0; fc_reg = '0; res = '0; filt_en = 1'b0;

        // reset state
        #1;
        model_reset();
        check_reset_now("rst");
        repeat (2) cycle();
        rst = 1'b0;

        // full-scale swing from reset codes, tick every cycle
        first = '{-1, -1};
        low = '{1'b0, 1'b0};
        filt_en = 1'b1; fc_reg = 11'h7FF; res = 4'hF; tick = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (!dset[k]) low[k] = 1'b1;
                else if (low[k] && first[k] < 0) first[k] = i;
            end
        end
        for (int k = 0; k < 2; k++) begin
`ifdef BIAS_DAC_SLEW_EN
            exp_first = 2 + 15 * DIVS[k];
`else
            exp_first = 3;
`endif
            check($sformatf("settle_lat[%0d]", k), first[k], exp_first);
            check($sformatf("full_fc[%0d]", k), dfc[k], 15);
            check($sformatf("full_q[%0d]", k), dq[k], 0);
        end

`ifdef BIAS_DAC_SLEW_EN
        // retarget mid-ramp: up to 6, then down to 3 without overshoot
        filt_en = 1'b0;
        settle("park", 200);
        filt_en = 1'b1; fc_reg = 11'h7FF; tick = 1'b1;
        c = 0;
        while (dfc[0] != 4'd6 && c < 60) begin
            cycle();
            c++;
        end
        check("reach6", dfc[0], 6);
        fc_reg = 11'h180;
        peak = 6;
        prev_fc[0] = 6;
        c = 0;
        while (c < 100 && !(c > 3 && dset[0] && dset[1])) begin
            cycle();
            c++;
            if (int'(dfc[0]) > peak) peak = dfc[0];
            if (int'(dfc[0]) != prev_fc[0]) vals.push_back(int'(dfc[0]));
            prev_fc[0] = dfc[0];
        end
        check("retgt_peak", peak, 6);
        check("retgt_nchg", vals.size(), 3);
        if (vals.size() == 3) begin
            check("retgt_v0", vals[0], 5);
            check("retgt_v1", vals[1], 4);
            check("retgt_v2", vals[2], 3);
        end
`endif

        // randomized inputs and ticks
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                fc_reg  = 11'($urandom);
                res     = 4'($urandom);
                filt_en = ($urandom_range(0, 3) != 0);
            end
            tick = 1'($urandom_range(0, 1));
            cycle();
        end

        // settle at fc=12, then park with sparse ticks
        filt_en = 1'b1; fc_reg = 11'h600; res = 4'($urandom);
        settle("fc12", 300);
        check("fc12_fc0", dfc[0], 12);
        filt_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prev_fc[k] = dfc[k];
            prev_q[k] = dq[k];
        end
        last_chg = -1;
        c = 0;
        while (c < 450 && !(c > 3 && dset[0] && dset[1])) begin
            tick = (c % 7 == 0);
            cycle();
            c++;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("mono_fc[%0d]", k), int'(int'(dfc[k]) <= prev_fc[k]), 1);
                check($sformatf("mono_q[%0d]", k), int'(int'(dq[k]) >= prev_q[k]), 1);
            end
`ifdef BIAS_DAC_SLEW_EN
            if (int'(dfc[1]) != prev_fc[1]) begin
                if (last_chg >= 0) check("tick_gap", c - last_chg, 21);
                last_chg = c;
            end
`endif
            for (int k = 0; k < 2; k++) begin
                prev_fc[k] = dfc[k];
                prev_q[k] = dq[k];
            end
        end
        check("park_fc", dfc[1], 0);
        check("park_q", dq[1], 15);

        // reset pulse mid-ramp, then ramp restarts from reset codes
        filt_en = 1'b1; fc_reg = 11'h7FF; res = 4'h0; tick = 1'b1;
        repeat (12) cycle();
        rst = 1'b1;
        #1;
        check_reset_now("midrst");
        model_reset();
        cycle();
        rst = 1'b0;
        settle("restart", 200);
        check("restart_fc", dfc[1], 15);
        check("restart_q", dq[1], 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
